ram_rd_check: RTL and testbench
===============================

RAM_RD_CHECK -- requirements
Module: ram_rd_check

Interface
REQ-001 Parameter RD_LAT, default 1, sets RAM read latency in cycles from rd_en/addr to valid rd_data; legal range 1..3.
REQ-002 Parameter ADDR_W, default 5, sets RAM address width.
REQ-003 Parameter DATA_W, default 8, sets RAM data width.
REQ-004 Parameter DATA_OFS, default 0, is the expected-data offset: expected = zero-extended addr + DATA_OFS, mod 2^DATA_W.
REQ-005 clk  in  1  single clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 ram_rd_en  in  1  read enable presented to the RAM this cycle.
REQ-008 ram_addr  in  ADDR_W  read address presented to the RAM this cycle.
REQ-009 ram_rd_data  in  DATA_W  RAM read data, valid RD_LAT cycles after the matching ram_rd_en.
REQ-010 clr_err  in  1  one-cycle pulse; clears err_flag, err_cnt, first_err_addr.
REQ-011 chk_valid  out  1  high for each cycle a word is compared.
REQ-012 chk_err  out  1  high with chk_valid when the compared word mismatches.
REQ-013 err_flag  out  1  sticky; set by any mismatch.
REQ-014 err_cnt  out  8  total mismatches, saturating at 255.
REQ-015 first_err_addr  out  ADDR_W  address of the first mismatch since reset/clear.
REQ-016 pass_done  out  1  one-cycle pulse at the end of each read burst.
REQ-017 pass_ok  out  1  valid with pass_done; high if the burst had zero mismatches.

Function
REQ-018 ram_rd_en and ram_addr shall be delayed by an RD_LAT-deep shift pipeline (en_d, addr_d) aligned to ram_rd_data.
REQ-019 chk_valid and chk_err shall be registered: asserted in the cycle after en_d=1, i.e. RD_LAT+1 cycles after ram_rd_en.
REQ-020 chk_err = (ram_rd_data != addr_d + DATA_OFS), evaluated only when en_d=1; chk_err=0 whenever chk_valid=0.
REQ-021 FSM states IDLE, CHECK, REPORT; IDLE->CHECK on en_d=1; CHECK stays while en_d=1; CHECK->REPORT on en_d=0; REPORT->IDLE unconditionally, or REPORT->CHECK if en_d=1 in that cycle.
REQ-022 Per-burst mismatch flag bad_pass is cleared on IDLE->CHECK entry and set by any mismatch while in CHECK.
REQ-023 pass_done shall pulse for exactly one cycle while in REPORT; pass_ok = NOT bad_pass, including a mismatch on the burst's last word.
REQ-024 A burst of one word shall still yield exactly one chk_valid and one pass_done.
REQ-025 err_cnt shall increment by 1 per mismatch and hold at 255; err_flag sets on the first mismatch.
REQ-026 first_err_addr shall capture addr_d only on a mismatch while err_flag=0.
REQ-027 clr_err coincident with a mismatch: clear wins for that cycle, the mismatch is discarded from err_cnt/err_flag/first_err_addr, still reported on chk_err and bad_pass.
REQ-028 Address wrap (2^ADDR_W-1 -> 0) within a burst shall need no special handling; the expected value follows addr_d.
REQ-029 Back-to-back bursts separated by one idle cycle of en_d shall each produce their own pass_done.

Reset
REQ-030 On rst=1 at a clock edge: FSM=IDLE; pipeline en_d=0, addr_d=0; chk_valid, chk_err, err_flag, pass_done, pass_ok, bad_pass = 0; err_cnt=0; first_err_addr=0.
REQ-031 Reset mid-burst shall abort it with no pass_done; checking restarts on the next en_d rising edge after rst deasserts.

Structure
REQ-032 FSM state encoding and the err_cnt saturation constant (255) shall live in a shared package, ram_chk_pkg.
REQ-033 The RD_LAT delay line shall be a sub-module, ram_lat_pipe, parameterised by depth and width.

Verification
REQ-034 RD_LAT=1, DATA_OFS=0: 32-cycle burst, addr 0..31, data=addr -> 32 chk_valid, chk_err=0, one pass_done with pass_ok=1, err_cnt=0.
REQ-035 Same burst with data at addr 7 forced to 0xAA -> one chk_err, pass_ok=0, err_cnt=1, err_flag=1, first_err_addr=7.
REQ-036 Corrupt addr 31 only (last word) -> pass_ok=0 on pass_done; next clean burst -> pass_ok=1 while err_flag stays 1.
REQ-037 Feed 300 mismatching words -> err_cnt holds 255; then clr_err -> err_cnt=0, err_flag=0, first_err_addr=0.
REQ-038 RD_LAT=3, one-word burst at addr 5, data 5 -> chk_valid exactly 4 cycles after ram_rd_en, one pass_done, pass_ok=1.
REQ-039 Assert rst at word 10 of a 32-word burst -> all outputs 0 next cycle, no pass_done; the following burst checks normally.

Source files
------------

// File: rtl/ram_chk_pkg.sv
// Shared definitions for the RAM read-back checker: FSM encoding and
// the saturation limit of the mismatch counter.
package ram_chk_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    REPORT = 2'd2
  } chk_state_t;

  localparam logic [7:0] ERR_CNT_MAX = 8'd255;

endpackage

// File: rtl/ram_rd_check_if.sv
// RAM read port as seen by the checker: the master drives the RAM request
// and returns read data; the checker only observes it.
interface ram_rd_check_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);

  logic              ram_rd_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rd_data;

  modport master (output ram_rd_en, output ram_addr, output ram_rd_data);
  modport slave  (input  ram_rd_en, input  ram_addr, input  ram_rd_data);

endinterface

// File: rtl/ram_lat_pipe.sv
// Fixed-depth shift register used to align the read request with the
// RAM's returned data.
module ram_lat_pipe #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/ram_rd_check.sv
// Read-back checker: compares RAM data against addr + DATA_OFS, keeps
// sticky error statistics and reports a pass/fail verdict per read burst.
module ram_rd_check
  import ram_chk_pkg::*;
#(
  parameter int RD_LAT   = 1,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int DATA_OFS = 0
) (
  input  logic              clk,
  input  logic              rst,
  ram_rd_check_if.slave     ram,
  input  logic              clr_err,
  output logic              chk_valid,
  output logic              chk_err,
  output logic              err_flag,
  output logic [7:0]        err_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic              pass_done,
  output logic              pass_ok
);

  logic              en_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] exp_data;
  logic              mismatch;
  logic              bad_pass;
  chk_state_t        state, state_nxt;

  ram_lat_pipe #(
    .DEPTH (RD_LAT),
    .WIDTH (ADDR_W + 1)
  ) u_lat_pipe (
    .clk  (clk),
    .rst  (rst),
    .din  ({ram.ram_rd_en, ram.ram_addr}),
    .dout ({en_d, addr_d})
  );

  // Expected word wraps modulo 2^DATA_W, so address wrap needs no special case
  assign exp_data = DATA_W'(addr_d) + DATA_W'(DATA_OFS);
  assign mismatch = en_d && (ram.ram_rd_data != exp_data);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pass_done = 1'b0;
    pass_ok   = 1'b0;
    case (state)
      IDLE:    if (en_d) state_nxt = CHECK;
      CHECK:   if (!en_d) state_nxt = REPORT;
      REPORT: begin
        state_nxt = en_d ? CHECK : IDLE;
        pass_done = 1'b1;
        pass_ok   = !bad_pass;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The first word of a burst is compared on the entry cycle, so it seeds bad_pass
  always_ff @(posedge clk) begin
    if (rst) begin
      chk_valid <= 1'b0;
      chk_err   <= 1'b0;
      bad_pass  <= 1'b0;
    end else begin
      chk_valid <= en_d;
      chk_err   <= mismatch;
      if (state != CHECK && en_d) bad_pass <= mismatch;
      else if (mismatch)          bad_pass <= 1'b1;
    end
  end

  // A clear in the same cycle as a mismatch drops that mismatch from the stats
  always_ff @(posedge clk) begin
    if (rst || clr_err) begin
      err_flag       <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else if (mismatch) begin
      if (err_cnt != ERR_CNT_MAX) err_cnt <= err_cnt + 8'd1;
      err_flag <= 1'b1;
      if (!err_flag) first_err_addr <= addr_d;
    end
  end

endmodule

// File: tb/tb_ram_rd_check.sv
// Bench for ram_rd_check: a scoreboard tracks every compared word and burst
// verdict of an RD_LAT=1 instance; an RD_LAT=3 instance checks latency.
module tb_ram_rd_check;

  logic clk;
  logic rst;
  logic clr1, clr3;
  logic corrupt1;

  ram_rd_check_if #(.ADDR_W(5), .DATA_W(8)) if1 ();
  ram_rd_check_if #(.ADDR_W(5), .DATA_W(8)) if3 ();

  logic       chk_valid1, chk_err1, err_flag1, pass_done1, pass_ok1;
  logic [7:0] err_cnt1;
  logic [4:0] first_err_addr1;
  logic       chk_valid3, chk_err3, err_flag3, pass_done3, pass_ok3;
  logic [7:0] err_cnt3;
  logic [4:0] first_err_addr3;

  ram_rd_check #(.RD_LAT(1), .ADDR_W(5), .DATA_W(8), .DATA_OFS(0)) dut1 (
    .clk(clk), .rst(rst), .ram(if1), .clr_err(clr1),
    .chk_valid(chk_valid1), .chk_err(chk_err1), .err_flag(err_flag1),
    .err_cnt(err_cnt1), .first_err_addr(first_err_addr1),
    .pass_done(pass_done1), .pass_ok(pass_ok1)
  );

  ram_rd_check #(.RD_LAT(3), .ADDR_W(5), .DATA_W(8), .DATA_OFS(0)) dut3 (
    .clk(clk), .rst(rst), .ram(if3), .clr_err(clr3),
    .chk_valid(chk_valid3), .chk_err(chk_err3), .err_flag(err_flag3),
    .err_cnt(err_cnt3), .first_err_addr(first_err_addr3),
    .pass_done(pass_done3), .pass_ok(pass_ok3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models: data = addr unless the word is deliberately corrupted
  logic [7:0] d3a, d3b;
  always @(posedge clk) begin
    if1.ram_rd_data <= corrupt1 ? 8'hAA : 8'(if1.ram_addr);
    d3a             <= 8'(if3.ram_addr);
    d3b             <= d3a;
    if3.ram_rd_data <= d3b;
  end

  int vectors = 0;
  int miscompares = 0;
  bit exp_err [$];
  bit exp_pass [$];
  int valid_cnt1 = 0;
  int pd_cnt1 = 0;
  bit sb_e;

  function automatic void check_output(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_valid1) begin
      valid_cnt1++;
      if (exp_err.size() == 0) check_output("chk_valid_unexpected", chk_valid1, 0);
      else begin
        sb_e = exp_err.pop_front();
        check_output("chk_err", chk_err1, sb_e);
      end
    end
    if (pass_done1) begin
      pd_cnt1++;
      if (exp_pass.size() == 0) check_output("pass_done_unexpected", pass_done1, 0);
      else begin
        sb_e = exp_pass.pop_front();
        check_output("pass_ok", pass_ok1, sb_e);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    if1.ram_rd_en = 1'b0;
    corrupt1      = 1'b0;
    repeat (n) step();
  endtask

  // One burst on dut1; bad_addr < 0 means no single corrupted address
  task automatic apply_stimulus(input int start, input int len, input int bad_addr, input bit all_bad);
    bit bp = 1'b0;
    bit bad;
    logic [4:0] a;
    for (int i = 0; i < len; i++) begin
      a   = 5'(start + i);
      bad = all_bad || (int'(a) == bad_addr);
      bp  = bp | bad;
      if1.ram_rd_en = 1'b1;
      if1.ram_addr  = a;
      corrupt1      = bad;
      exp_err.push_back(bad);
      if (i == len - 1) exp_pass.push_back(!bp);
      step();
    end
    if1.ram_rd_en = 1'b0;
    corrupt1      = 1'b0;
  endtask

  initial begin
    int pd0, v0, lat, nval, npd;
    rst = 1'b1; clr1 = 1'b0; clr3 = 1'b0; corrupt1 = 1'b0;
    if1.ram_rd_en = 1'b0; if1.ram_addr = '0;
    if3.ram_rd_en = 1'b0; if3.ram_addr = '0;
    step(); step();
    check_output("rst_chk_valid", chk_valid1, 0);
    check_output("rst_chk_err", chk_err1, 0);
    check_output("rst_err_flag", err_flag1, 0);
    check_output("rst_err_cnt", err_cnt1, 0);
    check_output("rst_first_err_addr", first_err_addr1, 0);
    check_output("rst_pass_done", pass_done1, 0);
    check_output("rst_pass_ok", pass_ok1, 0);
    rst = 1'b0;
    step();

    $display("[TB] clean 32-word burst");
    pd0 = pd_cnt1; v0 = valid_cnt1;
    apply_stimulus(0, 32, -1, 0); idle(5);
    check_output("clean_valid_count", valid_cnt1 - v0, 32);
    check_output("clean_pass_count", pd_cnt1 - pd0, 1);
    check_output("clean_err_cnt", err_cnt1, 0);
    check_output("clean_err_flag", err_flag1, 0);

    $display("[TB] corrupt word at addr 7");
    apply_stimulus(0, 32, 7, 0); idle(5);
    check_output("bad7_err_cnt", err_cnt1, 1);
    check_output("bad7_err_flag", err_flag1, 1);
    check_output("bad7_first_err_addr", first_err_addr1, 7);

    $display("[TB] corrupt last word, then clean burst");
    apply_stimulus(0, 32, 31, 0); idle(5);
    check_output("bad31_err_cnt", err_cnt1, 2);
    check_output("bad31_first_err_addr", first_err_addr1, 7);
    apply_stimulus(0, 32, -1, 0); idle(5);
    check_output("clean2_err_flag", err_flag1, 1);
    check_output("clean2_err_cnt", err_cnt1, 2);

    $display("[TB] back-to-back bursts, wrap, single word");
    pd0 = pd_cnt1; v0 = valid_cnt1;
    apply_stimulus(0, 4, -1, 0); idle(1);
    apply_stimulus(4, 2, 5, 0); idle(5);
    check_output("b2b_pass_count", pd_cnt1 - pd0, 2);
    check_output("b2b_err_cnt", err_cnt1, 3);
    apply_stimulus(30, 4, -1, 0); idle(5);
    pd0 = pd_cnt1; v0 = valid_cnt1;
    apply_stimulus(20, 1, -1, 0); idle(5);
    check_output("single_valid_count", valid_cnt1 - v0, 1);
    check_output("single_pass_count", pd_cnt1 - pd0, 1);

    $display("[TB] 300 mismatching words, saturation and clear");
    apply_stimulus(0, 300, -1, 1); idle(5);
    check_output("sat_err_cnt", err_cnt1, 255);
    check_output("sat_first_err_addr", first_err_addr1, 7);
    clr1 = 1'b1; step(); clr1 = 1'b0; step();
    check_output("clr_err_cnt", err_cnt1, 0);
    check_output("clr_err_flag", err_flag1, 0);
    check_output("clr_first_err_addr", first_err_addr1, 0);

    $display("[TB] clear coincident with mismatch");
    apply_stimulus(9, 1, 9, 0);
    clr1 = 1'b1; step(); clr1 = 1'b0;
    idle(5);
    check_output("clrhit_err_cnt", err_cnt1, 0);
    check_output("clrhit_err_flag", err_flag1, 0);
    check_output("clrhit_first_err_addr", first_err_addr1, 0);
    apply_stimulus(12, 1, 12, 0); idle(5);
    check_output("after_clr_err_cnt", err_cnt1, 1);
    check_output("after_clr_first_err_addr", first_err_addr1, 12);

    $display("[TB] reset at word 10 of a burst");
    pd0 = pd_cnt1;
    for (int i = 0; i < 10; i++) begin
      if1.ram_rd_en = 1'b1; if1.ram_addr = 5'(i); corrupt1 = 1'b0;
      exp_err.push_back(1'b0);
      step();
    end
    if1.ram_addr = 5'd10; rst = 1'b1;
    step();
    check_output("abort_chk_valid", chk_valid1, 0);
    check_output("abort_err_cnt", err_cnt1, 0);
    check_output("abort_err_flag", err_flag1, 0);
    check_output("abort_first_err_addr", first_err_addr1, 0);
    check_output("abort_pass_done", pass_done1, 0);
    rst = 1'b0; if1.ram_rd_en = 1'b0;
    exp_err.delete(); exp_pass.delete();
    idle(5);
    check_output("abort_no_pass_done", pd_cnt1 - pd0, 0);
    pd0 = pd_cnt1; v0 = valid_cnt1;
    apply_stimulus(0, 32, -1, 0); idle(5);
    check_output("post_abort_valid_count", valid_cnt1 - v0, 32);
    check_output("post_abort_pass_count", pd_cnt1 - pd0, 1);

    $display("[TB] RD_LAT=3 single word at addr 5");
    lat = -1; nval = 0; npd = 0;
    if3.ram_rd_en = 1'b1; if3.ram_addr = 5'd5;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 1) if3.ram_rd_en = 1'b0;
      if (chk_valid3) begin
        nval++;
        if (lat < 0) lat = k;
        check_output("lat3_chk_err", chk_err3, 0);
      end
      if (pass_done3) begin
        npd++;
        check_output("lat3_pass_ok", pass_ok3, 1);
      end
    end
    check_output("lat3_latency", lat, 4);
    check_output("lat3_valid_count", nval, 1);
    check_output("lat3_pass_count", npd, 1);
    check_output("lat3_err_cnt", err_cnt3, 0);

    check_output("sb_err_drained", exp_err.size(), 0);
    check_output("sb_pass_drained", exp_pass.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
